cpu6_trap_ctrl: RTL and testbench
=================================

CPU6_TRAP_CTRL -- requirements
Module: cpu6_trap_ctrl

Interface
REQ-001 Parameter XLEN, default 32, datapath and PC width.
REQ-002 Parameter N_IRQ, default 4 (legal 1..16), number of interrupt sources.
REQ-003 Parameter VECTORED_EN, default 1; 1 enables vectored interrupt entry.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 excp_pc  in  XLEN  PC of instruction currently in decode.
REQ-007 excp_illinstr  in  1  decode flags illegal instruction.
REQ-008 mret  in  1  decode flags mret instruction.
REQ-009 irq_src  in  N_IRQ  level interrupt requests; bit 0 is highest priority.
REQ-010 irq_en  in  N_IRQ  per-source enable (mie bits).
REQ-011 csr_mstatus_mie  in  1  global interrupt enable.
REQ-012 csr_mtvec  in  XLEN  trap base [XLEN-1:2], mode [1:0] (00 direct, 01 vectored).
REQ-013 csr_mepc  in  XLEN  return address for mret.
REQ-014 drain_ack  in  1  writeback stage reports pipeline empty.
REQ-015 stall_req  out  1  freeze fetch PC.
REQ-016 instr_kill  out  1  replace fetched instruction with NOP.
REQ-017 flush_pc_ena  out  1  one-cycle PC redirect strobe.
REQ-018 flush_pc  out  XLEN  redirect target.
REQ-019 mepc_wr_ena / mepc_wr  out  1 / XLEN  mepc write strobe and data.
REQ-020 mcause_wr_ena / mcause_wr  out  1 / XLEN  mcause write strobe and data.
REQ-021 mstatus_trap  out  1  pulse: MPIE<=MIE, MIE<=0.
REQ-022 mstatus_mret  out  1  pulse: MIE<=MPIE, MPIE<=1.
REQ-023 irq_pending  out  N_IRQ  registered pending vector (mip view).
REQ-024 busy  out  1  FSM not in IDLE.

Function
REQ-025 FSM states IDLE, DRAIN, TRAP, RET; encoding free.
REQ-026 irq_pending[i] sets on any cycle irq_src[i]&irq_en[i]; clears only in TRAP cycle of a taken source i; set and clear in same cycle: clear wins, re-set next cycle if still asserted.
REQ-027 Interrupt eligible when csr_mstatus_mie=1 and any irq_pending bit=1; winner = lowest set index.
REQ-028 IDLE priority: excp_illinstr > eligible interrupt > mret; selected event captures kind, cause and excp_pc into registers and moves to DRAIN next cycle.
REQ-029 Illegal instruction: cause code 2, interrupt bit 0; interrupt i: cause code 16+i, bit XLEN-1 = 1; mret: no cause.
REQ-030 instr_kill SHALL be 1 combinationally in IDLE whenever an interrupt is eligible, and in DRAIN.
REQ-031 DRAIN: stall_req=1, instr_kill=1; stay until drain_ack=1 sampled, then TRAP (exception/interrupt) or RET (mret); drain_ack already 1 on first DRAIN cycle gives one DRAIN cycle.
REQ-032 TRAP (exactly one cycle): flush_pc_ena, mepc_wr_ena, mcause_wr_ena, mstatus_trap = 1; mepc_wr = captured PC; mcause_wr = captured cause; next state IDLE.
REQ-033 flush_pc in TRAP = {csr_mtvec[XLEN-1:2],2'b00}, plus 4*cause code only when interrupt, VECTORED_EN=1 and mtvec mode=01; sum truncated to XLEN (wraps).
REQ-034 RET (exactly one cycle): flush_pc_ena=1, flush_pc=csr_mepc with bits [1:0] forced 0, mstatus_mret=1; next state IDLE.
REQ-035 New events in DRAIN/TRAP/RET are ignored; only pending register keeps collecting; event re-evaluated in IDLE next cycle.
REQ-036 Minimum latency event->flush_pc_ena: 2 cycles (IDLE sample, DRAIN, TRAP).
REQ-037 mode values 10/11 treated as direct.
REQ-038 All strobes zero outside stated states; busy=1 in DRAIN/TRAP/RET.

Reset
REQ-039 reset=0 forces IDLE, irq_pending=0, captured regs=0, all outputs 0 asynchronously, regardless of state.
REQ-040 Reset released mid-drain: block resumes in IDLE, no trap strobes issued.

Verification
REQ-041 illinstr=1, excp_pc=0x100, mtvec=0x800, drain_ack=1 -> TRAP 2 cycles later: flush_pc=0x800, mepc_wr=0x100, mcause_wr=0x2, mstatus_trap=1 for one cycle.
REQ-042 N_IRQ=4, irq_src=4'b1010, irq_en=4'hF, mie=1, mtvec=0x801 -> winner 1, mcause_wr=0x80000011, flush_pc=0x844; irq_pending[1] clears in TRAP, bit 3 stays set.
REQ-043 mret=1, csr_mepc=0x203, drain_ack held 0 for 5 cycles -> stall_req=1 for 6 cycles, then flush_pc=0x200, mstatus_mret=1.
REQ-044 illinstr and eligible irq same cycle -> cause 2 taken; irq trap follows after return to IDLE.
REQ-045 irq with mie=0 -> irq_pending set, instr_kill=0, no DRAIN; mie 0->1 -> DRAIN next cycle.
REQ-046 reset asserted in DRAIN -> all outputs 0 immediately; no flush_pc_ena after release.

Source files
------------

// File: rtl/cpu6_trap_ctrl_if.sv
// Pipeline <-> trap controller signal bundle: decode events, interrupt lines,
// CSR views and drain handshake in; redirect, CSR write and status strobes out.
interface cpu6_trap_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int N_IRQ = 4
);
    logic [XLEN-1:0]  excp_pc;
    logic             excp_illinstr;
    logic             mret;
    logic [N_IRQ-1:0] irq_src;
    logic [N_IRQ-1:0] irq_en;
    logic             csr_mstatus_mie;
    logic [XLEN-1:0]  csr_mtvec;
    logic [XLEN-1:0]  csr_mepc;
    logic             drain_ack;

    logic             stall_req;
    logic             instr_kill;
    logic             flush_pc_ena;
    logic [XLEN-1:0]  flush_pc;
    logic             mepc_wr_ena;
    logic [XLEN-1:0]  mepc_wr;
    logic             mcause_wr_ena;
    logic [XLEN-1:0]  mcause_wr;
    logic             mstatus_trap;
    logic             mstatus_mret;
    logic [N_IRQ-1:0] irq_pending;
    logic             busy;

    modport master (
        output excp_pc, excp_illinstr, mret, irq_src, irq_en, csr_mstatus_mie,
               csr_mtvec, csr_mepc, drain_ack,
        input  stall_req, instr_kill, flush_pc_ena, flush_pc, mepc_wr_ena, mepc_wr,
               mcause_wr_ena, mcause_wr, mstatus_trap, mstatus_mret, irq_pending, busy
    );

    modport slave (
        input  excp_pc, excp_illinstr, mret, irq_src, irq_en, csr_mstatus_mie,
               csr_mtvec, csr_mepc, drain_ack,
        output stall_req, instr_kill, flush_pc_ena, flush_pc, mepc_wr_ena, mepc_wr,
               mcause_wr_ena, mcause_wr, mstatus_trap, mstatus_mret, irq_pending, busy
    );
endinterface

// File: rtl/cpu6_trap_ctrl.sv
// Trap controller: arbitrates illegal-instruction, interrupt and mret events,
// drains the pipeline, then issues the one-cycle trap entry or return redirect.
module cpu6_trap_ctrl #(
    parameter int XLEN        = 32,
    parameter int N_IRQ       = 4,
    parameter int VECTORED_EN = 1
) (
    input logic             clk,
    input logic             reset,
    cpu6_trap_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DRAIN, TRAP, RET} state_t;
    typedef enum logic [1:0] {EV_EXC, EV_IRQ, EV_MRET} kind_t;

    state_t           state;
    kind_t            kind;
    logic [XLEN-1:0]  cap_pc;
    logic [XLEN-1:0]  cap_cause;
    logic [3:0]       cap_idx;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] pend_clr;
    logic             eligible;
    logic [3:0]       win_idx;
    logic [XLEN-1:0]  irq_cause;
    logic [XLEN-1:0]  trap_base;
    logic [XLEN-1:0]  vec_off;

    // Scan downwards so the lowest pending index is the one left standing.
    always_comb begin
        win_idx = '0;
        for (int unsigned i = N_IRQ; i > 0; i--) begin
            if (pending[i-1]) win_idx = 4'(i - 1);
        end
    end

    assign eligible = bus.csr_mstatus_mie & (|pending);

    always_comb begin
        irq_cause         = '0;
        irq_cause[XLEN-1] = 1'b1;
        irq_cause[4:0]    = 5'd16 + {1'b0, win_idx};
    end

    always_comb begin
        pend_clr = '0;
        if (state == TRAP && kind == EV_IRQ) pend_clr = N_IRQ'(1) << cap_idx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            kind      <= EV_EXC;
            cap_pc    <= '0;
            cap_cause <= '0;
            cap_idx   <= '0;
            pending   <= '0;
        end else begin
            // Clear of the taken source overrides a same-cycle re-assertion.
            pending <= (pending | (bus.irq_src & bus.irq_en)) & ~pend_clr;
            case (state)
                IDLE: begin
                    if (bus.excp_illinstr) begin
                        kind      <= EV_EXC;
                        cap_pc    <= bus.excp_pc;
                        cap_cause <= XLEN'(2);
                        state     <= DRAIN;
                    end else if (eligible) begin
                        kind      <= EV_IRQ;
                        cap_pc    <= bus.excp_pc;
                        cap_cause <= irq_cause;
                        cap_idx   <= win_idx;
                        state     <= DRAIN;
                    end else if (bus.mret) begin
                        kind      <= EV_MRET;
                        cap_pc    <= bus.excp_pc;
                        cap_cause <= '0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.drain_ack) state <= (kind == EV_MRET) ? RET : TRAP;
                end
                TRAP:    state <= IDLE;
                RET:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign trap_base = {bus.csr_mtvec[XLEN-1:2], 2'b00};
    assign vec_off   = (kind == EV_IRQ && VECTORED_EN != 0 && bus.csr_mtvec[1:0] == 2'b01)
                     ? XLEN'({cap_cause[4:0], 2'b00}) : '0;

    always_comb begin
        bus.stall_req     = 1'b0;
        bus.instr_kill    = 1'b0;
        bus.flush_pc_ena  = 1'b0;
        bus.flush_pc      = '0;
        bus.mepc_wr_ena   = 1'b0;
        bus.mepc_wr       = '0;
        bus.mcause_wr_ena = 1'b0;
        bus.mcause_wr     = '0;
        bus.mstatus_trap  = 1'b0;
        bus.mstatus_mret  = 1'b0;
        bus.busy          = (state != IDLE);
        case (state)
            IDLE: bus.instr_kill = eligible;
            DRAIN: begin
                bus.stall_req  = 1'b1;
                bus.instr_kill = 1'b1;
            end
            TRAP: begin
                bus.flush_pc_ena  = 1'b1;
                bus.flush_pc      = trap_base + vec_off;
                bus.mepc_wr_ena   = 1'b1;
                bus.mepc_wr       = cap_pc;
                bus.mcause_wr_ena = 1'b1;
                bus.mcause_wr     = cap_cause;
                bus.mstatus_trap  = 1'b1;
            end
            RET: begin
                bus.flush_pc_ena = 1'b1;
                bus.flush_pc     = {bus.csr_mepc[XLEN-1:2], 2'b00};
                bus.mstatus_mret = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.irq_pending = pending;
endmodule

// File: tb/tb_cpu6_trap_ctrl.sv
// Bench for cpu6_trap_ctrl: directed vector table, reset corner sequence, and
// randomized traffic checked against an event-level reference model.
module tb_cpu6_trap_ctrl;
    logic clk;
    logic reset;

    cpu6_trap_ctrl_if #(.XLEN(32), .N_IRQ(4)) bus ();

    cpu6_trap_ctrl #(.XLEN(32), .N_IRQ(4), .VECTORED_EN(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        ill;
        logic        mret;
        logic [31:0] pc;
        logic [3:0]  src;
        logic [3:0]  en;
        logic        mie;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic        ack;
    } in_t;

    typedef struct packed {
        logic        stall;
        logic        kill;
        logic        fena;
        logic [31:0] fpc;
        logic        mepc_en;
        logic [31:0] mepc;
        logic        mc_en;
        logic [31:0] mcause;
        logic        trap;
        logic        mret;
        logic [3:0]  pend;
        logic        busy;
    } outs_t;

    typedef struct {
        in_t   i;
        outs_t o;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t tbl[$];

    function automatic in_t mk_in(logic ill, logic mret, logic [31:0] pc, logic [3:0] src,
                                  logic [3:0] en, logic mie, logic [31:0] mtvec,
                                  logic [31:0] mepc, logic ack);
        in_t v;
        v.ill = ill; v.mret = mret; v.pc = pc; v.src = src; v.en = en;
        v.mie = mie; v.mtvec = mtvec; v.mepc = mepc; v.ack = ack;
        return v;
    endfunction

    function automatic outs_t o_idle(logic kill, logic [3:0] pend);
        outs_t o = '0;
        o.kill = kill; o.pend = pend;
        return o;
    endfunction

    function automatic outs_t o_drain(logic [3:0] pend);
        outs_t o = '0;
        o.stall = 1'b1; o.kill = 1'b1; o.busy = 1'b1; o.pend = pend;
        return o;
    endfunction

    function automatic outs_t o_trap(logic [31:0] fpc, logic [31:0] mepc,
                                     logic [31:0] mcause, logic [3:0] pend);
        outs_t o = '0;
        o.fena = 1'b1; o.fpc = fpc; o.mepc_en = 1'b1; o.mepc = mepc;
        o.mc_en = 1'b1; o.mcause = mcause; o.trap = 1'b1; o.busy = 1'b1; o.pend = pend;
        return o;
    endfunction

    function automatic outs_t o_ret(logic [31:0] fpc, logic [3:0] pend);
        outs_t o = '0;
        o.fena = 1'b1; o.fpc = fpc; o.mret = 1'b1; o.busy = 1'b1; o.pend = pend;
        return o;
    endfunction

    function automatic outs_t dut_outs();
        outs_t o;
        o.stall = bus.stall_req;     o.kill = bus.instr_kill;
        o.fena = bus.flush_pc_ena;   o.fpc = bus.flush_pc;
        o.mepc_en = bus.mepc_wr_ena; o.mepc = bus.mepc_wr;
        o.mc_en = bus.mcause_wr_ena; o.mcause = bus.mcause_wr;
        o.trap = bus.mstatus_trap;   o.mret = bus.mstatus_mret;
        o.pend = bus.irq_pending;    o.busy = bus.busy;
        return o;
    endfunction

    task automatic drive(input in_t v);
        bus.excp_illinstr   = v.ill;
        bus.mret            = v.mret;
        bus.excp_pc         = v.pc;
        bus.irq_src         = v.src;
        bus.irq_en          = v.en;
        bus.csr_mstatus_mie = v.mie;
        bus.csr_mtvec       = v.mtvec;
        bus.csr_mepc        = v.mepc;
        bus.drain_ack       = v.ack;
    endtask

    task automatic check(input string name, input int idx, input outs_t act, input outs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Reference model state: one outstanding event, described by what it is
    // and whether its drain has completed.
    bit [3:0]  m_pend;
    bit        m_busy;
    bit        m_final;
    int        m_kind;   // 0 illegal instr, 1 interrupt, 2 mret
    int        m_irq;
    bit [31:0] m_pc;

    function automatic outs_t model_out(input in_t v);
        outs_t e = '0;
        e.pend = m_pend;
        if (!m_busy) begin
            e.kill = v.mie && (m_pend != 0);
        end else if (!m_final) begin
            e.stall = 1'b1; e.kill = 1'b1; e.busy = 1'b1;
        end else begin
            e.busy = 1'b1;
            e.fena = 1'b1;
            if (m_kind == 2) begin
                e.fpc  = v.mepc & 32'hFFFF_FFFC;
                e.mret = 1'b1;
            end else begin
                e.mepc_en = 1'b1; e.mepc = m_pc; e.mc_en = 1'b1; e.trap = 1'b1;
                e.fpc = v.mtvec & 32'hFFFF_FFFC;
                if (m_kind == 0) begin
                    e.mcause = 32'd2;
                end else begin
                    e.mcause = 32'h8000_0000 + 32'(16 + m_irq);
                    if (v.mtvec[1:0] == 2'b01) e.fpc = e.fpc + 32'(4 * (16 + m_irq));
                end
            end
        end
        return e;
    endfunction

    task automatic model_step(input in_t v);
        bit [3:0] np;
        np = m_pend | (v.src & v.en);
        if (m_busy && m_final && m_kind == 1) np[m_irq] = 1'b0;
        if (!m_busy) begin
            if (v.ill) begin
                m_busy = 1; m_final = 0; m_kind = 0; m_pc = v.pc;
            end else if (v.mie && m_pend != 0) begin
                m_busy = 1; m_final = 0; m_kind = 1; m_pc = v.pc;
                m_irq = 0;
                while (!m_pend[m_irq]) m_irq++;
            end else if (v.mret) begin
                m_busy = 1; m_final = 0; m_kind = 2; m_pc = v.pc;
            end
        end else if (!m_final) begin
            if (v.ack) m_final = 1;
        end else begin
            m_busy = 0; m_final = 0;
        end
        m_pend = np;
    endtask

    initial begin
        in_t   v;
        outs_t z = '0;
        logic [31:0] r;

        reset = 1'b0;
        drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1 check("reset_state", 0, dut_outs(), z);
        #11 reset = 1'b1;
        @(posedge clk); #1;

        // Illegal instruction, direct mtvec
        tbl.push_back('{mk_in(1,0,'h100,0,0,0,'h800,0,1), o_idle(0,0)});
        tbl.push_back('{mk_in(0,0,'h100,0,0,0,'h800,0,1), o_drain(0)});
        tbl.push_back('{mk_in(0,0,'h100,0,0,0,'h800,0,0), o_trap('h800,'h100,'h2,0)});
        tbl.push_back('{mk_in(0,0,'h100,0,0,0,'h800,0,0), o_idle(0,0)});
        // Two sources, vectored mtvec: source 1 wins, source 3 stays pending
        tbl.push_back('{mk_in(0,0,'h300,'b1010,'hF,1,'h801,0,1), o_idle(0,0)});
        tbl.push_back('{mk_in(0,0,'h300,'b1010,'hF,1,'h801,0,1), o_idle(1,'b1010)});
        tbl.push_back('{mk_in(0,0,'h300,0,'hF,1,'h801,0,1), o_drain('b1010)});
        tbl.push_back('{mk_in(0,0,'h300,0,'hF,1,'h801,0,1), o_trap('h844,'h300,'h8000_0011,'b1010)});
        tbl.push_back('{mk_in(0,0,'h300,0,'hF,0,'h801,0,1), o_idle(0,'b1000)});
        // mret with a long drain
        tbl.push_back('{mk_in(0,1,'h300,0,'hF,0,'h801,'h203,0), o_idle(0,'b1000)});
        for (int k = 0; k < 5; k++)
            tbl.push_back('{mk_in(0,0,'h300,0,'hF,0,'h801,'h203,0), o_drain('b1000)});
        tbl.push_back('{mk_in(0,0,'h300,0,'hF,0,'h801,'h203,1), o_drain('b1000)});
        tbl.push_back('{mk_in(0,0,'h300,0,'hF,0,'h801,'h203,0), o_ret('h200,'b1000)});
        tbl.push_back('{mk_in(0,0,'h300,0,'hF,0,'h801,'h203,0), o_idle(0,'b1000)});
        // Pending source taken once global enable rises
        tbl.push_back('{mk_in(0,0,'h300,0,'hF,1,'h801,0,1), o_idle(1,'b1000)});
        tbl.push_back('{mk_in(0,0,'h300,0,'hF,1,'h801,0,1), o_drain('b1000)});
        tbl.push_back('{mk_in(0,0,'h300,0,'hF,1,'h801,0,1), o_trap('h84C,'h300,'h8000_0013,'b1000)});
        tbl.push_back('{mk_in(0,0,'h300,0,'hF,1,'h801,0,1), o_idle(0,0)});
        // Illegal instruction beats a simultaneous interrupt; interrupt follows
        tbl.push_back('{mk_in(0,0,'h400,'b0001,'hF,1,'h801,0,1), o_idle(0,0)});
        tbl.push_back('{mk_in(1,0,'h400,0,'hF,1,'h801,0,1), o_idle(1,'b0001)});
        tbl.push_back('{mk_in(0,0,'h400,0,'hF,1,'h801,0,1), o_drain('b0001)});
        tbl.push_back('{mk_in(0,0,'h400,0,'hF,1,'h801,0,1), o_trap('h800,'h400,'h2,'b0001)});
        tbl.push_back('{mk_in(0,0,'h400,0,'hF,1,'h801,0,1), o_idle(1,'b0001)});
        tbl.push_back('{mk_in(0,0,'h400,0,'hF,1,'h801,0,1), o_drain('b0001)});
        tbl.push_back('{mk_in(0,0,'h400,0,'hF,1,'h801,0,1), o_trap('h840,'h400,'h8000_0010,'b0001)});
        tbl.push_back('{mk_in(0,0,'h400,0,'hF,0,'h801,0,1), o_idle(0,0)});

        foreach (tbl[k]) begin
            drive(tbl[k].i);
            #4 check("vector", k, dut_outs(), tbl[k].o);
            @(posedge clk); #1;
        end

        // Reset asserted mid-drain, then released
        drive(mk_in(1, 0, 'h500, 0, 0, 0, 'h800, 0, 0));
        @(posedge clk); #1;
        drive(mk_in(0, 0, 'h500, 0, 0, 0, 'h800, 0, 0));
        #3 check("drain_before_reset", 0, dut_outs(), o_drain(0));
        reset = 1'b0;
        #1 check("reset_in_drain", 0, dut_outs(), z);
        @(posedge clk); #1;
        reset = 1'b1;
        drive(mk_in(0, 0, 'h500, 0, 0, 0, 'h800, 0, 1));
        for (int k = 0; k < 4; k++) begin
            #4 check("after_reset_release", k, dut_outs(), z);
            @(posedge clk); #1;
        end

        // Randomized traffic against the reference model
        m_pend = '0; m_busy = 0; m_final = 0; m_kind = 0; m_irq = 0; m_pc = '0;
        for (int k = 0; k < 3000; k++) begin
            v.ill   = ($urandom_range(0, 9) == 0);
            v.mret  = ($urandom_range(0, 5) == 0);
            v.pc    = $urandom;
            v.src   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            v.en    = 4'($urandom_range(0, 15));
            v.mie   = ($urandom_range(0, 3) != 0);
            r       = $urandom;
            if ($urandom_range(0, 7) == 0) r = 32'hFFFF_FFF0 | (r & 32'h3);
            v.mtvec = r;
            v.mepc  = $urandom;
            v.ack   = ($urandom_range(0, 1) == 1);
            drive(v);
            #4 check("random", k, dut_outs(), model_out(v));
            @(posedge clk);
            model_step(v);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
